// File: rtl/a1_scaler_pkg.sv
// Shared definitions for the a1_scaler frequency divider: default sizes,
// the bit positions used to split the stage chain into the two snapshot
// channel words, and a helper that builds both words from one count value.
package a1_scaler_pkg;

    localparam int SCALER_STAGES = 32;
    localparam int SCALER_CH_W   = 14;

    // CH4 takes cnt[LO_TOP:0] under FS01; CH3 takes cnt[HI_TOP:HI_LO].
    localparam int LO_TOP = 12;
    localparam int HI_LO  = 13;
    localparam int HI_TOP = 26;

    typedef struct packed {
        logic [SCALER_CH_W-1:0] hi;   // FS28..FS15
        logic [SCALER_CH_W-1:0] lo;   // FS14..FS01
    } snap_t;

    // Both channel words come from the same count value, so they can never tear.
    function automatic snap_t pack_snapshot(input logic [HI_TOP:0] low_cnt,
                                            input logic            fs01);
        snap_t s;
        s.lo = {low_cnt[LO_TOP:0], fs01};
        s.hi = low_cnt[HI_TOP:HI_LO];
        return s;
    endfunction

endpackage

// File: rtl/a1_scaler_if.sv
// Signal bundle between the timer/consumers and the a1_scaler.
// The master side drives FS01 and the control strobes; the scaler is the slave.
interface a1_scaler_if
    import a1_scaler_pkg::*;
#(
    parameter int STAGES = SCALER_STAGES,
    parameter int CH_W   = SCALER_CH_W
);
    logic              FS01;
    logic              SNAP;
    logic              SCLOAD;
    logic [STAGES-1:0] SCDATA;
    logic [STAGES-1:0] FS;
    logic [STAGES-1:0] FA;
    logic [STAGES-1:0] FB;
    logic [CH_W-1:0]   CH3;
    logic [CH_W-1:0]   CH4;
    logic              SNAPV;

    modport master (
        output FS01, SNAP, SCLOAD, SCDATA,
        input  FS, FA, FB, CH3, CH4, SNAPV
    );

    modport slave (
        input  FS01, SNAP, SCLOAD, SCDATA,
        output FS, FA, FB, CH3, CH4, SNAPV
    );

endinterface

// File: rtl/a1_scaler_edge.sv
// FS01 sampling register and falling-event detect. A fall is seen when the
// registered level is 1 and the live FS01 is 0; the event only feeds the
// count register in the parent, so no input reaches an output unregistered.
module a1_scaler_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic fs01_i,
    output logic fs01_q,
    output logic fall_o
);

    logic fs01_d;

    // Next value of the FS01 sampling register.
    always_comb begin
        fs01_d = fs01_i;
    end

    // FS01 sampling register; clears on reset so a low FS01 at release is not a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs01_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of process order.
            fs01_q <= fs01_d;
        end
    end

    assign fall_o = fs01_q & ~fs01_i;

endmodule

// File: rtl/a1_scaler.sv
// Binary scaler chain driven by the timer's FS01 square wave. The chain of
// divide-by-two stages is collapsed into one counter that advances on each
// FS01 fall; per-stage rise/fall strobes come from comparing the next count
// against the current one. A snapshot path captures the low 27 stages plus
// FS01 into two channel words in a single cycle for the I/O read path.
module a1_scaler
    import a1_scaler_pkg::*;
#(
    parameter int STAGES = SCALER_STAGES,
    parameter int CH_W   = SCALER_CH_W
) (
    input  logic         SIM_CLK,
    input  logic         RESET_,
    a1_scaler_if.slave   bus
);

    logic              fs01_q;
    logic              fall;

    logic [STAGES-1:0] cnt_d,   cnt_q;
    logic [STAGES-1:0] fa_d,    fa_q;
    logic [STAGES-1:0] fb_d,    fb_q;
    snap_t             snap_d,  snap_q;
    logic              snapv_d, snapv_q;

    a1_scaler_edge u_edge (
        .clk    (SIM_CLK),
        .rst_n  (RESET_),
        .fs01_i (bus.FS01),
        .fs01_q (fs01_q),
        .fall_o (fall)
    );

    // Next count (load beats increment), stage strobes and snapshot capture.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        snapv_d = bus.SNAP;

        if (bus.SCLOAD) begin
            cnt_d = bus.SCDATA;
        end else if (fall) begin
            cnt_d = cnt_q + 1'b1;
        end

        fa_d = cnt_d & ~cnt_q;
        fb_d = ~cnt_d & cnt_q;

        // Snapshot sees the count before this cycle's load or increment.
        if (bus.SNAP) begin
            snap_d = pack_snapshot(cnt_q[HI_TOP:0], fs01_q);
        end
    end

    // State register for the stage chain, strobes and snapshot words.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) begin
            cnt_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            // NOTE: the snapshot words are ordinary holding registers, not a memory, and must read 0 after reset.
            snap_q  <= '0;
            snapv_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            snap_q  <= snap_d;
            snapv_q <= snapv_d;
        end
    end

    assign bus.FS    = cnt_q;
    assign bus.FA    = fa_q;
    assign bus.FB    = fb_q;
    assign bus.CH3   = snap_q.hi;
    assign bus.CH4   = snap_q.lo;
    assign bus.SNAPV = snapv_q;

endmodule

// File: tb/tb_a1_scaler.sv
// Bench for a1_scaler: a behavioural model (integer count, arithmetic
// snapshot split) is checked against the DUT every cycle, alongside directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_a1_scaler;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    a1_scaler_if #(.STAGES(32), .CH_W(14)) bus ();

    a1_scaler #(.STAGES(32), .CH_W(14)) dut (
        .SIM_CLK (clk),
        .RESET_  (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    longint m_fs, m_fa, m_fb, m_ch3, m_ch4;
    longint m_snapv, m_fs01;

    always @(posedge clk or negedge rst_n) begin
        longint old_v, new_v;
        if (!rst_n) begin
            m_fs = 0; m_fa = 0; m_fb = 0;
            m_ch3 = 0; m_ch4 = 0; m_snapv = 0; m_fs01 = 0;
        end else begin
            old_v = m_fs;
            if (bus.SNAP) begin
                m_ch4 = (old_v * 2 + m_fs01) % 16384;
                m_ch3 = (old_v / 8192) % 16384;
            end
            m_snapv = bus.SNAP ? 1 : 0;
            if (bus.SCLOAD)
                new_v = longint'(bus.SCDATA);
            else if (m_fs01 == 1 && bus.FS01 == 1'b0)
                new_v = (old_v + 1) % 64'h1_0000_0000;
            else
                new_v = old_v;
            m_fa = new_v & ~old_v;
            m_fb = old_v & ~new_v;
            m_fs = new_v;
            m_fs01 = bus.FS01 ? 1 : 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("cmp_fs",    bus.FS,           32'(m_fs));
            check("cmp_fa",    bus.FA,           32'(m_fa));
            check("cmp_fb",    bus.FB,           32'(m_fb));
            check("cmp_ch3",   32'(bus.CH3),     32'(m_ch3));
            check("cmp_ch4",   32'(bus.CH4),     32'(m_ch4));
            check("cmp_snapv", 32'(bus.SNAPV),   32'(m_snapv));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_fs"},    bus.FS,         32'h0);
        check({tag, "_fa"},    bus.FA,         32'h0);
        check({tag, "_fb"},    bus.FB,         32'h0);
        check({tag, "_ch3"},   32'(bus.CH3),   32'h0);
        check({tag, "_ch4"},   32'(bus.CH4),   32'h0);
        check({tag, "_snapv"}, 32'(bus.SNAPV), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fa_cnt, fb_cnt, hold;
        rst_n      = 1'b0;
        bus.FS01   = 1'b0;
        bus.SNAP   = 1'b0;
        bus.SCLOAD = 1'b0;
        bus.SCDATA = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Eight FS01 periods: 3-bit count walks 1..7,0; four FA[0] and four FB[0] pulses.
        fa_cnt = 0;
        fb_cnt = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 4; c++) begin
                bus.FS01 = (c < 2);
                step();
                fa_cnt += int'(bus.FA[0]);
                fb_cnt += int'(bus.FB[0]);
                if (c == 2)
                    check("div_strobe_at_fall", 32'(bus.FA[0] ^ bus.FB[0]), 32'h1);
            end
            check("div_fs_lsb3", 32'(bus.FS[2:0]), 32'((p + 1) % 8));
        end
        check("div_fa0_pulses", 32'(fa_cnt), 32'd4);
        check("div_fb0_pulses", 32'(fb_cnt), 32'd4);
        check("div_fs_total",   bus.FS,      32'd8);

        // Load all ones, then one fall: wrap to 0 with every FB bit set.
        bus.FS01 = 1'b1; step(); step();
        bus.SCLOAD = 1'b1; bus.SCDATA = 32'hFFFF_FFFF; step();
        check("load_ones_fs", bus.FS, 32'hFFFF_FFFF);
        bus.SCLOAD = 1'b0; bus.FS01 = 1'b0; step();
        check("wrap_fs", bus.FS, 32'h0);
        check("wrap_fb", bus.FB, 32'hFFFF_FFFF);
        check("wrap_fa", bus.FA, 32'h0);
        step();
        check("wrap_fb_one_cycle", bus.FB, 32'h0);

        // Snapshot split with FS01 high.
        bus.FS01 = 1'b1; step(); step();
        bus.SCLOAD = 1'b1; bus.SCDATA = 32'h0000_3FFF; step();
        bus.SCLOAD = 1'b0; bus.SNAP = 1'b1; step();
        check("snap_ch4",   32'(bus.CH4),   32'h3FFF);
        check("snap_ch3",   32'(bus.CH3),   32'h0001);
        check("snap_valid", 32'(bus.SNAPV), 32'h1);
        bus.SNAP = 1'b0; step();
        check("snap_valid_drop", 32'(bus.SNAPV), 32'h0);
        check("snap_hold_ch4",   32'(bus.CH4),   32'h3FFF);

        // Snapshot coincident with a fall takes the pre-increment count.
        bus.SCLOAD = 1'b1; bus.SCDATA = 32'h0000_1FFF; step();
        bus.SCLOAD = 1'b0; bus.FS01 = 1'b0; bus.SNAP = 1'b1; step();
        check("snapfall_ch4", 32'(bus.CH4), 32'h3FFF);
        check("snapfall_ch3", 32'(bus.CH3), 32'h0000);
        check("snapfall_fs",  bus.FS,       32'h0000_2000);
        bus.SNAP = 1'b0; step();

        // Load wins over a coincident fall.
        bus.FS01 = 1'b1; step(); step();
        bus.SCLOAD = 1'b1; bus.SCDATA = 32'd5; bus.FS01 = 1'b0; step();
        check("load_vs_fall_fs", bus.FS, 32'd5);
        bus.SCLOAD = 1'b0; step();
        check("load_vs_fall_hold", bus.FS, 32'd5);

        // Asynchronous reset mid-count; a low FS01 at release must not count.
        bus.FS01 = 1'b1;
        bus.SCLOAD = 1'b1; bus.SCDATA = 32'h0000_1234; step();
        bus.SCLOAD = 1'b0; step();
        bus.SNAP = 1'b1; step();
        bus.SNAP = 1'b0;
        check("prerst_fs",  bus.FS,       32'h0000_1234);
        check("prerst_ch4", 32'(bus.CH4), 32'h2469);
        #1 rst_n = 1'b0; bus.FS01 = 1'b0;
        #1 check_all_zero("async_rst");
        #3 rst_n = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_no_count", bus.FS, 32'h0);
        end
        bus.FS01 = 1'b1; step(); step();
        bus.FS01 = 1'b0; step();
        check("post_rst_first_fall", bus.FS, 32'h1);
        step();

        // Randomized phase: FS01 levels held 2..4 cycles, random snaps and loads.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.FS01 = ~bus.FS01;
                hold = int'($urandom_range(2, 4));
            end
            hold--;
            bus.SNAP   = ($urandom_range(0, 5) == 0);
            bus.SCLOAD = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 2))
                0:       bus.SCDATA = $urandom;
                1:       bus.SCDATA = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: bus.SCDATA = 32'h0000_1FF0 | 32'($urandom_range(0, 15));
            endcase
            step();
        end

        bus.SNAP = 1'b0; bus.SCLOAD = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
